ifu: RTL and testbench



---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_predecode.sv | 22 ++
 rtl/ifu.sv | 61 ++++++
 tb/tb_ifu.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants for the instruction fetch unit: NOP encoding, RV32I opcodes,
// reset vector and immediate extraction helpers used by the pre-decoder.
package ifu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OPC_W  = 7;

    localparam logic [XLEN-1:0]  NOP          = 32'h0000_0013;
    localparam logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0]  INSTR_BYTES  = 32'd4;

    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

    // J-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // B-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_predecode.sv
// Static predictor: JAL and backward conditional branches are predicted taken;
// JALR and forward branches fall through.
module ifu_predecode
    import ifu_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] ip,
    output logic            predict_taken_c,
    output logic [XLEN-1:0] target_c
);

    logic is_jal;
    logic is_branch;

    always_comb begin
        is_jal          = (instr[OPC_W-1:0] == OP_JAL);
        is_branch       = (instr[OPC_W-1:0] == OP_BRANCH);
        predict_taken_c = is_jal | (is_branch & instr[31]);
        target_c        = ip + (is_jal ? imm_j(instr) : imm_b(instr));
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns ip, latches the fetched word into IR for IDU.
// Define IFU_BRANCH_PREDICT_EN to enable JAL / backward-branch pre-decode redirect.
module ifu
    import ifu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] ip,
    input  logic [XLEN-1:0] i_in,
    output logic            IFU_valid,
    input  logic            IDU_ready,
    output logic [XLEN-1:0] IR,
    input  logic            jump,
    input  logic [XLEN-1:0] EXU_jump_ip
);

    logic            advance_c;
    logic [XLEN-1:0] next_ip_c;

`ifdef IFU_BRANCH_PREDICT_EN
    logic            predict_taken_c;
    logic [XLEN-1:0] predict_target_c;

    ifu_predecode u_predecode (
        .instr           (i_in),
        .ip              (ip),
        .predict_taken_c (predict_taken_c),
        .target_c        (predict_target_c)
    );

    always_comb begin
        next_ip_c = predict_taken_c ? predict_target_c : ip + INSTR_BYTES;
    end
`else
    always_comb begin
        next_ip_c = ip + INSTR_BYTES;
    end
`endif

    always_comb begin
        advance_c = IDU_ready | ~IFU_valid;
    end

    // Priority: reset > redirect > advance > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ip        <= RESET_VECTOR;
            IR        <= NOP;
            IFU_valid <= 1'b0;
        end else if (jump) begin
            ip        <= {EXU_jump_ip[XLEN-1:2], 2'b00};
            IR        <= NOP;
            IFU_valid <= 1'b0;
        end else if (advance_c) begin
            ip        <= next_ip_c;
            IR        <= i_in;
            IFU_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed literal cases plus randomized traffic
// checked every cycle against a behavioural fetch model.
module tb_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] ip;
    logic [31:0] i_in;
    logic        IFU_valid;
    logic        IDU_ready;
    logic [31:0] IR;
    logic        jump;
    logic [31:0] EXU_jump_ip;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ip, m_ir;
    logic        m_v;
    logic [31:0] n_ip, n_ir;
    logic        n_v;

    ifu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ip          (ip),
        .i_in        (i_in),
        .IFU_valid   (IFU_valid),
        .IDU_ready   (IDU_ready),
        .IR          (IR),
        .jump        (jump),
        .EXU_jump_ip (EXU_jump_ip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-latency instruction memory, addressed by word, wrapping every 1 KiB.
    always_comb i_in = mem[ip[9:2]];

    // Address of the next fetch given the word fetched at a, from the ISA rules.
    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [31:0] w);
        int off;
        off = 4;
`ifdef IFU_BRANCH_PREDICT_EN
        if (w[6:0] == 7'h6f)
            off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
        else if (w[6:0] == 7'h63 && w[31])
            off = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
`endif
        return a + 32'(off);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ip", ip, m_ip);
        chk("IR", IR, m_ir);
        chk("IFU_valid", 32'(IFU_valid), 32'(m_v));
    endtask

    // Drive one cycle of inputs, advance the model, check all outputs after the edge.
    task automatic step(input logic r, input logic rdy, input logic j, input logic [31:0] tgt);
        rst_n       = r;
        IDU_ready   = rdy;
        jump        = j;
        EXU_jump_ip = tgt;
        if (!r) begin
            n_ip = 32'h0; n_ir = 32'h13; n_v = 1'b0;
        end else if (j) begin
            n_ip = tgt & 32'hffff_fffc; n_ir = 32'h13; n_v = 1'b0;
        end else if (rdy || !m_v) begin
            n_ir = mem[m_ip[9:2]];
            n_ip = model_next(m_ip, n_ir);
            n_v  = 1'b1;
        end else begin
            n_ip = m_ip; n_ir = m_ir; n_v = m_v;
        end
        @(posedge clk);
        m_ip = n_ip; m_ir = n_ir; m_v = n_v;
        @(negedge clk);
        compare_all();
    endtask

    logic [31:0] exp_ip;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'h13;
        mem[2]  = 32'hffdff06f;
        mem[16] = 32'h00000463;
        mem[17] = 32'hfe000ee3;
        mem[64] = 32'h12345678;
        m_ip = 32'h0; m_ir = 32'h13; m_v = 1'b0;

        // Reset held two edges.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_ip", ip, 32'h0);
        chk("rst_IR", IR, 32'h13);
        chk("rst_valid", 32'(IFU_valid), 32'd0);

        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("first_ip", ip, 32'h4);
        chk("first_valid", 32'(IFU_valid), 32'd1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("second_ip", ip, 32'h8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("jal_IR", IR, 32'hffdff06f);
`ifdef IFU_BRANCH_PREDICT_EN
        chk("jal_ip", ip, 32'h4);
`else
        chk("jal_ip", ip, 32'hc);
`endif

        // Redirect with unaligned target, then forward and backward branch.
        step(1'b1, 1'b1, 1'b1, 32'h41);
        chk("redir_ip", ip, 32'h40);
        chk("redir_IR", IR, 32'h13);
        chk("redir_valid", 32'(IFU_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("fwd_ip", ip, 32'h44);
        chk("fwd_IR", IR, 32'h00000463);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("bwd_IR", IR, 32'hfe000ee3);
`ifdef IFU_BRANCH_PREDICT_EN
        exp_ip = 32'h40;
`else
        exp_ip = 32'h48;
`endif
        chk("bwd_ip", ip, exp_ip);

        // Three-cycle stall holds everything.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_ip", ip, exp_ip);
            chk("stall_IR", IR, 32'hfe000ee3);
            chk("stall_valid", 32'(IFU_valid), 32'd1);
        end

        // Redirect during stall.
        step(1'b1, 1'b0, 1'b1, 32'h100);
        chk("stall_redir_ip", ip, 32'h100);
        chk("stall_redir_valid", 32'(IFU_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("target_IR", IR, 32'h12345678);
        chk("target_valid", 32'(IFU_valid), 32'd1);
        chk("target_ip", ip, 32'h104);

        // Address wrap past the top of memory.
        step(1'b1, 1'b1, 1'b1, 32'hffff_fffe);
        chk("wrap_top_ip", ip, 32'hffff_fffc);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_ip", ip, 32'h0);

        // Reset during a stall with a redirect pending: reset wins.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h200);
        chk("rst_mid_ip", ip, 32'h0);
        chk("rst_mid_valid", 32'(IFU_valid), 32'd0);

        // Randomized program and traffic.
        for (int k = 0; k < 256; k++) begin
            logic [31:0] w;
            w = $urandom;
            case ($urandom_range(0, 4))
                0: mem[k] = {w[31:7], 7'b1101111};
                1: mem[k] = {w[31:7], 7'b1100011};
                2: mem[k] = {w[31:7], 7'b1100111};
                3: mem[k] = 32'h13;
                default: mem[k] = w;
            endcase
        end
        for (int c = 0; c < 3000; c++) begin
            logic r, rdy, j;
            r   = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            j   = ($urandom_range(0, 9) == 0);
            step(r, rdy, j, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
